// File: rtl/fpu_pkg.sv
// fpu_pkg: arbiter state encoding and FP32 constants shared by the divider arbiter files
package fpu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arb_state_t;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after last_i
//   req_i  : request vector
//   last_i : index of the previous winner; search starts at last_i+1
//   gnt_o  : one-hot grant, zero when no request
//   idx_o  : index of the granted requester
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int W = $clog2(N);
  logic [W-1:0] j;
  // scan from the farthest candidate (last itself) to the nearest (last+1); the nearest valid overwrites
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = W'((int'(last_i) + i) % N);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/fpu_div_arbiter.sv
// fpu_div_arbiter: shares one FP32 divider among NUM_REQ requesters, one operation in flight
//   req_valid_i/req_ready_o/req_a_i/req_b_i : per-requester request channel (operands packed 32 bits each)
//   resp_valid_o/resp_ready_i               : per-requester response handshake
//   resp_value_o/resp_timeout_o             : shared result bus and aborted-operation flag
//   div_a_o/div_b_o/div_exec_strobe_o       : divider operands and start pulse
//   div_done_strobe_i/div_z_i               : divider completion and result
//   div_reset_o                             : divider reset (reset release and watchdog abort)
//   busy_o/timeout_o                        : not idle / sticky watchdog-fired flag
module fpu_div_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_a_i,
  input  logic [NUM_REQ*32-1:0] req_b_i,
  output logic [NUM_REQ-1:0]    resp_valid_o,
  input  logic [NUM_REQ-1:0]    resp_ready_i,
  output logic [31:0]           resp_value_o,
  output logic                  resp_timeout_o,
  output logic [31:0]           div_a_o,
  output logic [31:0]           div_b_o,
  output logic                  div_exec_strobe_o,
  input  logic                  div_done_strobe_i,
  input  logic [31:0]           div_z_i,
  output logic                  div_reset_o,
  output logic                  busy_o,
  output logic                  timeout_o
);
  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t state_q, state_d;
  logic [LW-1:0] last_q, last_d, grant_q, grant_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d, resp_value_q, resp_value_d;
  logic resp_to_q, resp_to_d, timeout_q, timeout_d, div_reset_q, div_reset_d;
  logic [NUM_REQ-1:0] gnt;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (req_valid_i),
    .last_i(last_q),
    .gnt_o (gnt),
    .idx_o (win)
  );
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      last_q       <= LW'(NUM_REQ - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      resp_value_q <= '0;
      resp_to_q    <= 1'b0;
      timeout_q    <= 1'b0;
      div_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      resp_value_q <= resp_value_d;
      resp_to_q    <= resp_to_d;
      timeout_q    <= timeout_d;
      div_reset_q  <= div_reset_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    resp_value_d = resp_value_q;
    resp_to_d    = resp_to_q;
    timeout_d    = timeout_q;
    div_reset_d  = 1'b0;
    case (state_q)
      IDLE: if (|req_valid_i) begin
        div_a_d = req_a_i[{win, 5'd0} +: 32];
        div_b_d = req_b_i[{win, 5'd0} +: 32];
        grant_d = win;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      // done is checked first so it wins over a simultaneous watchdog expiry
      WAIT: if (div_done_strobe_i) begin
        resp_value_d = div_z_i;
        resp_to_d    = 1'b0;
        state_d      = RESPOND;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        resp_value_d = FP32_QNAN;
        resp_to_d    = 1'b1;
        timeout_d    = 1'b1;
        div_reset_d  = 1'b1;
        state_d      = RESPOND;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESPOND: if (resp_ready_i[grant_q]) begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready_o           = (state_q == IDLE) ? gnt : '0;
    resp_valid_o          = '0;
    resp_valid_o[grant_q] = (state_q == RESPOND);
    resp_value_o          = resp_value_q;
    resp_timeout_o        = resp_to_q;
    div_a_o               = div_a_q;
    div_b_o               = div_b_q;
    div_exec_strobe_o     = (state_q == ISSUE);
    div_reset_o           = div_reset_q;
    busy_o                = (state_q != IDLE);
    timeout_o             = timeout_q;
  end
endmodule
